// File: rtl/tone_gen_pkg.sv
// Shared constants, state encoding and note-period lookup for the tone generator.
// Combinational helpers only; no latency or flow control of their own.
// The lookup and the generator share the half-period width defined here.
package tone_gen_pkg;

    localparam int DEF_PERIOD_W   = 19;
    localparam int DEF_MIN_PERIOD = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tone_state_t;

    typedef logic [DEF_PERIOD_W-1:0] period_t;

    // Half-period counts for C4..B4 with a 50 MHz clock.
    function automatic period_t half_period(input logic [3:0] idx);
        period_t p;
        case (idx)
            4'd0:    p = period_t'(95557);
            4'd1:    p = period_t'(90194);
            4'd2:    p = period_t'(85131);
            4'd3:    p = period_t'(80353);
            4'd4:    p = period_t'(75843);
            4'd5:    p = period_t'(71587);
            4'd6:    p = period_t'(67569);
            4'd7:    p = period_t'(63776);
            4'd8:    p = period_t'(60197);
            4'd9:    p = period_t'(56818);
            4'd10:   p = period_t'(53629);
            4'd11:   p = period_t'(50619);
            default: p = '0;
        endcase
        return p;
    endfunction

    // Lowest selected note wins when several select bits are set.
    function automatic period_t note_period(input logic [11:0] note_sel);
        period_t p;
        p = '0;
        for (int i = 11; i >= 0; i--) begin
            if (note_sel[i]) p = half_period(4'(i));
        end
        return p;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator with clean note-off (always ends low); TONE_GEN_OCTAVE_EN adds octave shift.
// Latency: audio_out rises one cycle after start; each half lasts exactly period_q cycles.
// No backpressure: inputs are sampled every cycle, period only at note start and half boundaries.
module tone_gen
    import tone_gen_pkg::*;
#(
    parameter int PERIOD_W   = DEF_PERIOD_W,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                note_valid,
    input  logic [PERIOD_W-1:0] period,
`ifdef TONE_GEN_OCTAVE_EN
    input  logic [1:0]          octave,
`endif
    output logic                audio_out,
    output logic                edge_tick,
    output logic                busy,
    output logic [PERIOD_W-1:0] period_q
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE   = PERIOD_W'(1);

    tone_state_t         state;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] eff_period;
    logic                start;
    logic                boundary;

`ifdef TONE_GEN_OCTAVE_EN
    assign eff_period = period >> octave;
`else
    assign eff_period = period;
`endif

    assign start    = enable & note_valid & (eff_period >= MIN_P);
    assign boundary = (cnt == period_q - ONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            audio_out <= 1'b0;
            edge_tick <= 1'b0;
            busy      <= 1'b0;
            period_q  <= '0;
        end else begin
            edge_tick <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt       <= '0;
                    audio_out <= 1'b0;
                    if (start) begin
                        period_q  <= eff_period;
                        audio_out <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (boundary) begin
                        cnt       <= '0;
                        audio_out <= ~audio_out;
                        edge_tick <= 1'b1;
                        if (start) period_q <= eff_period;
                        else       state    <= DRAIN;
                    end else begin
                        cnt <= cnt + ONE;
                        if (!(enable && note_valid)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Finish the current half; a high half falls here so no pulse is truncated.
                    if (boundary) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (audio_out) begin
                            audio_out <= 1'b0;
                            edge_tick <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                        if (start) state <= RUN;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    audio_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: directed cycle tables for the listed scenarios, then random
// stimulus compared against an event-level model of the tone (remaining-cycles view).
module tb_tone_gen;

    localparam int PW    = 19;
    localparam int MIN_P = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          note_valid = 1'b0;
    logic [PW-1:0] period = '0;
    logic          audio_out;
    logic          edge_tick;
    logic          busy;
    logic [PW-1:0] period_q;
`ifdef TONE_GEN_OCTAVE_EN
    logic [1:0]    octave = 2'd0;
`endif

    tone_gen #(.PERIOD_W(PW), .MIN_PERIOD(MIN_P)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .note_valid (note_valid),
        .period     (period),
`ifdef TONE_GEN_OCTAVE_EN
        .octave     (octave),
`endif
        .audio_out  (audio_out),
        .edge_tick  (edge_tick),
        .busy       (busy),
        .period_q   (period_q)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       rst;
        bit       en;
        bit       nv;
        int       p;
        bit [1:0] oct;
        bit       a;
        bit       t;
        bit       b;
        int       q;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit e, input bit n, input int p, input bit [1:0] o,
                       input bit a, input bit t, input bit b, input int q);
        vec_t v;
        v.rst = r; v.en = e; v.nv = n; v.p = p; v.oct = o;
        v.a = a; v.t = t; v.b = b; v.q = q;
        vecs.push_back(v);
    endtask

    task automatic addn(input int cnt, input bit e, input bit n, input int p,
                        input bit a, input bit b, input int q);
        for (int i = 0; i < cnt; i++) add(0, e, n, p, 2'd0, a, 0, b, q);
    endtask

    // Reference model: tone level, remaining cycles in the current half, note held or released.
    bit m_busy, m_held, m_lvl, m_tick;
    int m_rem, m_pq;

    task automatic model_step();
        int  pe;
        bit  st;
        pe = int'(period);
`ifdef TONE_GEN_OCTAVE_EN
        pe = pe >> octave;
`endif
        st = enable && note_valid && (pe >= MIN_P);
        m_tick = 0;
        if (reset) begin
            m_busy = 0; m_held = 0; m_lvl = 0; m_pq = 0; m_rem = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_held = 1; m_lvl = 1; m_pq = pe; m_rem = pe - 1;
            end
        end else if (m_rem == 0) begin
            if (m_held) begin
                m_lvl  = !m_lvl;
                m_tick = 1;
                if (st) m_pq = pe;
                else    m_held = 0;
                m_rem = m_pq - 1;
            end else begin
                if (m_lvl) begin
                    m_lvl = 0; m_tick = 1;
                end
                m_busy = 0;
            end
        end else begin
            m_rem--;
            if (m_held && !(enable && note_valid)) m_held = 0;
            else if (!m_held && st)               m_held = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        // Basic tone, then period change 4->6 two cycles into a high half.
        add(1, 1, 1, 4, 0, 0, 0, 0, 0);
        addn(4, 1, 1, 4, 1, 1, 4);
        add(0, 1, 1, 4, 0, 0, 1, 1, 4); addn(3, 1, 1, 4, 0, 1, 4);
        add(0, 1, 1, 4, 0, 1, 1, 1, 4); addn(1, 1, 1, 4, 1, 1, 4);
        addn(2, 1, 1, 6, 1, 1, 4);
        add(0, 1, 1, 6, 0, 0, 1, 1, 6); addn(5, 1, 1, 6, 0, 1, 6);
        add(0, 1, 1, 6, 0, 1, 1, 1, 6); addn(5, 1, 1, 6, 1, 1, 6);
        add(0, 1, 1, 6, 0, 0, 1, 1, 6);
        // Note-off one cycle into a high half.
        add(1, 0, 0, 4, 0, 0, 0, 0, 0);
        add(0, 1, 1, 4, 0, 1, 0, 1, 4); addn(3, 1, 0, 4, 1, 1, 4);
        add(0, 1, 0, 4, 0, 0, 1, 0, 4); addn(1, 1, 0, 4, 0, 0, 4);
        // Note-off in a low half.
        add(1, 0, 0, 4, 0, 0, 0, 0, 0);
        addn(4, 1, 1, 4, 1, 1, 4);
        add(0, 1, 1, 4, 0, 0, 1, 1, 4); addn(3, 1, 0, 4, 0, 1, 4);
        addn(2, 1, 0, 4, 0, 0, 4);
        // Drain then resume before the boundary.
        add(1, 0, 0, 4, 0, 0, 0, 0, 0);
        addn(1, 1, 1, 4, 1, 1, 4); addn(1, 1, 0, 4, 1, 1, 4); addn(2, 1, 1, 4, 1, 1, 4);
        add(0, 1, 1, 4, 0, 0, 1, 1, 4); addn(3, 1, 1, 4, 0, 1, 4);
        add(0, 1, 1, 4, 0, 1, 1, 1, 4);
        // Invalid period, disabled, then smallest legal period with note-off.
        add(1, 0, 0, 1, 0, 0, 0, 0, 0);
        addn(3, 1, 1, 1, 0, 0, 0); addn(2, 0, 1, 4, 0, 0, 0);
        addn(2, 1, 1, 2, 1, 1, 2);
        add(0, 1, 1, 2, 0, 0, 1, 1, 2); addn(1, 1, 1, 2, 0, 1, 2);
        add(0, 1, 1, 2, 0, 1, 1, 1, 2); addn(1, 1, 0, 2, 1, 1, 2);
        add(0, 1, 0, 2, 0, 0, 1, 0, 2);
        // Reset mid-RUN with start held through it.
        add(1, 0, 0, 4, 0, 0, 0, 0, 0);
        addn(2, 1, 1, 4, 1, 1, 4);
        add(1, 1, 1, 4, 0, 0, 0, 0, 0);
        addn(2, 1, 1, 4, 1, 1, 4);
`ifdef TONE_GEN_OCTAVE_EN
        add(1, 0, 0, 8, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 1, 8, 1, 1, 0, 1, 4);
        add(0, 1, 1, 8, 1, 0, 1, 1, 4);
        add(1, 0, 0, 3, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 3, 1, 0, 0, 0, 0);
`endif

        @(negedge clock);
        for (int i = 0; i < vecs.size(); i++) begin
            reset      = vecs[i].rst;
            enable     = vecs[i].en;
            note_valid = vecs[i].nv;
            period     = PW'(vecs[i].p);
`ifdef TONE_GEN_OCTAVE_EN
            octave     = vecs[i].oct;
`endif
            @(posedge clock); #1;
            check($sformatf("row%0d audio_out", i), int'(audio_out), int'(vecs[i].a));
            check($sformatf("row%0d edge_tick", i), int'(edge_tick), int'(vecs[i].t));
            check($sformatf("row%0d busy", i),      int'(busy),      int'(vecs[i].b));
            check($sformatf("row%0d period_q", i),  int'(period_q),  vecs[i].q);
        end

        // Random phase against the model.
        reset = 1; enable = 1; note_valid = 1; period = PW'(4);
`ifdef TONE_GEN_OCTAVE_EN
        octave = 2'd0;
`endif
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                reset  = ($urandom_range(0, 249) == 0);
                enable = ($urandom_range(0, 19) != 0);
                if ($urandom_range(0, 7) == 0) note_valid = ~note_valid;
                if ($urandom_range(0, 9) == 0) period = PW'($urandom_range(1, 7));
`ifdef TONE_GEN_OCTAVE_EN
                if ($urandom_range(0, 29) == 0) octave = 2'($urandom_range(0, 2));
`endif
            end
            model_step();
            @(posedge clock); #1;
            check($sformatf("rand%0d audio_out", c), int'(audio_out), int'(m_lvl));
            check($sformatf("rand%0d edge_tick", c), int'(edge_tick), int'(m_tick));
            check($sformatf("rand%0d busy", c),      int'(busy),      int'(m_busy));
            check($sformatf("rand%0d period_q", c),  int'(period_q),  m_pq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
